// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES pad responder and the host-side reader.
// Holds the state encoding, the button bit positions and the bus idle level.
package nes_pad_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int NUM_BUTTONS = 8;
    localparam int BTN_A       = 7;
    localparam int BTN_B       = 6;
    localparam int BTN_SELECT  = 5;
    localparam int BTN_START   = 4;
    localparam int BTN_UP      = 3;
    localparam int BTN_DOWN    = 2;
    localparam int BTN_LEFT    = 1;
    localparam int BTN_RIGHT   = 0;

    // A real pad with its shift register exhausted drives the line high.
    localparam logic DATA_IDLE = 1'b1;

    localparam logic [3:0] LAST_BIT = 4'd7;

    // The serial line is active-low, so the shift register holds released = 1.
    function automatic logic [7:0] pad_load_word(input logic [7:0] pressed);
        return ~pressed;
    endfunction

endpackage

// File: rtl/nes_pad_debounce.sv
// Single-button debouncer: the output follows the input only after the input
// has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module nes_pad_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic stable_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (din_i == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
            stable_d = din_i;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/nes_pad_responder.sv
// Emulates an NES controller on the host's latch / nes_clk / data lines,
// serving debounced local buttons and counting completed frames.
module nes_pad_responder
    import nes_pad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       latch,
    input  logic       nes_clk,
    input  logic [7:0] buttons,
    output logic       data,
    output logic [7:0] frame_cnt,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for the host to raise latch, line idles high
    // LOAD  | latch high, shift register tracks the debounced buttons
    // SHIFT | one bit per nes_clk rising edge, A already on the line
    // DONE  | all 8 bits delivered, line held high until next latch

    logic [SYNC_STAGES-1:0][9:0] sync_q;
    logic                        latch_s, nclk_s, nclk_rise;
    logic [7:0]                  btn_s, btn_db;

    logic [1:0] state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       data_q, data_d;
    logic       nclk_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {latch, nes_clk, buttons};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign latch_s   = sync_q[SYNC_STAGES-1][9];
    assign nclk_s    = sync_q[SYNC_STAGES-1][8];
    assign btn_s     = sync_q[SYNC_STAGES-1][7:0];
    assign nclk_rise = nclk_s & ~nclk_prev_q;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_db
        nes_pad_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .din_i    (btn_s[g]),
            .stable_o (btn_db[g])
        );
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (latch_s) begin
                    state_d = ST_LOAD;
                    sr_d    = pad_load_word(btn_db);
                end
            end
            ST_LOAD: begin
                if (latch_s) begin
                    sr_d = pad_load_word(btn_db);
                end else begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 4'd0;
                end
            end
            ST_SHIFT: begin
                // A latch overrides any shift edge seen in the same cycle.
                if (latch_s) begin
                    state_d = ST_LOAD;
                    sr_d    = pad_load_word(btn_db);
                end else if (nclk_rise) begin
                    sr_d      = {sr_q[6:0], DATA_IDLE};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d     = ST_DONE;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        data_d = ((state_d == ST_LOAD) || (state_d == ST_SHIFT)) ? sr_d[BTN_A] : DATA_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= 8'hFF;
            bit_cnt_q   <= 4'd0;
            frame_cnt_q <= 8'd0;
            data_q      <= DATA_IDLE;
            nclk_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            data_q      <= data_d;
            nclk_prev_q <= nclk_s;
        end
    end

    assign data      = data_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_SHIFT);

endmodule

// File: doc/nes_pad_responder.md
NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, clk cycles a button input must hold a new level before it is accepted.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on every asynchronous input.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port latch, input, 1, controller latch from the host reader; asynchronous to clk; high = parallel load.
REQ-006 SHALL have port nes_clk, input, 1, controller shift clock from the host reader; asynchronous to clk.
REQ-007 SHALL have port buttons, input, 8, raw pad buttons, active-high pressed, order [7:0] = A, B, Select, Start, Up, Down, Left, Right.
REQ-008 SHALL have port data, output, 1, serial button stream to the host reader, active-low (0 = pressed).
REQ-009 SHALL have port frame_cnt, output, 8, count of completed 8-bit frames.
REQ-010 SHALL have port busy, output, 1, high while in LOAD or SHIFT.

Function
REQ-011 SHALL pass latch, nes_clk and each buttons bit through SYNC_STAGES flops before use.
REQ-012 SHALL debounce each synchronized button independently: the stable value changes only after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreeing cycle clears that button's counter.
REQ-013 SHALL detect nes_clk rising edges and latch rising/falling edges from the synchronized signals; with SYNC_STAGES=2, data SHALL update on the 3rd clk edge after the input edge.
REQ-014 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-015 IDLE: data = 1; synchronized latch high -> LOAD.
REQ-016 LOAD: while latch is high, the 8-bit shift register reloads every cycle from the debounced buttons; data = ~A; latch low -> SHIFT with bit_cnt = 0.
REQ-017 SHIFT: each nes_clk rising edge advances one bit (order B, Select, Start, Up, Down, Left, Right) and increments bit_cnt; the edge that consumes Right (bit_cnt reaches 8) -> DONE with data = 1.
REQ-018 DONE: data = 1 for every further nes_clk edge (no-pad behaviour); latch high -> LOAD.
REQ-019 On entry to DONE, frame_cnt SHALL increment by 1, wrapping 255 -> 0.
REQ-020 Latch rising edge in SHIFT SHALL abort the frame (no frame_cnt increment) and go to LOAD.
REQ-021 Latch high and nes_clk rising edge detected in the same cycle: latch wins, no shift occurs.
REQ-022 nes_clk edges in IDLE or LOAD SHALL be ignored.
REQ-023 Button changes after the LOAD->SHIFT transition SHALL NOT affect the frame in progress.

Reset
REQ-024 On reset_n low, asynchronously: state = IDLE, data = 1, busy = 0, frame_cnt = 0, shift register = 8'hFF (all released), debounced buttons = 0, debounce counters = 0, synchronizer flops = 0.
REQ-025 Reset asserted mid-frame SHALL discard the frame; after release the block waits in IDLE for a latch.

Structure
REQ-026 State encoding, button bit-index constants and the DONE idle level SHALL live in a shared package nes_pad_pkg, reused by the host-side reader.
REQ-027 Debounce SHALL be one sub-module, nes_pad_debounce, instantiated 8 times (one per button).

Verification
REQ-028 Reset, then buttons = 8'b1000_0001 (A, Right) held > DEBOUNCE_CYCLES, 12 us latch pulse, 8 nes_clk pulses -> data sequence 0,1,1,1,1,1,1,0 then 1; frame_cnt = 1.
REQ-029 Button pulse shorter than DEBOUNCE_CYCLES (DEBOUNCE_CYCLES=16, pulse 10 cycles) -> frame reads all 1s.
REQ-030 Latch re-asserted after 3 nes_clk pulses -> frame aborted, frame_cnt unchanged, next full frame correct.
REQ-031 12 nes_clk pulses after a latch -> pulses 9-12 read 1; 256 full frames -> frame_cnt wraps to 0.
REQ-032 Latch high coincident with nes_clk rising -> data stays ~A, no bit advance.
REQ-033 reset_n low during bit 4 -> data = 1 and frame_cnt = 0 immediately; subsequent latch/shift frame correct.
